// File: rtl/mcu_rx_pkg.sv
// Shared types and defaults for the MCU pixel capture stage.
package mcu_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } rx_state_t;

  localparam int unsigned H_RES_DEF = 80;
  localparam int unsigned V_RES_DEF = 60;

  typedef logic [12:0] fb_addr_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser for one asynchronous level, with registered one-cycle
// rise/fall pulses taken from the synchronised output.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync_lvl;

  assign sync_lvl = sync_q[STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_lvl;
      rise_q <= sync_lvl & ~dly_q;
      fall_q <= ~sync_lvl & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/mcu_pixel_rx.sv
// Captures the MCU's asynchronous parallel pixel bus into the system clock and
// writes pixels into the 80x60 framebuffer with row/column addressing.
module mcu_pixel_rx
  import mcu_rx_pkg::*;
#(
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF,
  parameter int unsigned COL_W       = 7,
  parameter int unsigned ROW_W       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   CLK_100MHz,
  input  logic                   RST_N,
  input  logic [7:0]             MCU_DATA,
  input  logic                   MCU_WR,
  input  logic                   MCU_FRAME_N,
  output logic [ROW_W+COL_W-1:0] FB_ADDR,
  output logic [7:0]             FB_COLOR,
  output logic                   FB_WE,
  output logic                   FRAME_DONE,
  output logic                   ERR_OVERRUN,
  output logic                   ERR_SHORT,
  output logic                   BUSY
);

  logic wr_rise;
  logic wr_fall_unused;
  logic frame_rise;
  logic frame_fall;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_wr (
    .clk_i   (CLK_100MHz),
    .rst_ni  (RST_N),
    .async_i (MCU_WR),
    .rise_o  (wr_rise),
    .fall_o  (wr_fall_unused)
  );

  // FRAME_N is active-low: its synchronised rise closes the frame window.
  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_frame (
    .clk_i   (CLK_100MHz),
    .rst_ni  (RST_N),
    .async_i (MCU_FRAME_N),
    .rise_o  (frame_rise),
    .fall_o  (frame_fall)
  );

  logic [SYNC_STAGES-1:0][7:0] data_q;
  logic [7:0]                  data_sync;

  assign data_sync = data_q[SYNC_STAGES-1];

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
    end else begin
      data_q <= {data_q[SYNC_STAGES-2:0], MCU_DATA};
    end
  end

  rx_state_t        state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             col_end;
  logic             last_px;

  assign col_end = (col_q == COL_W'(H_RES - 1));
  assign last_px = col_end && (row_q == ROW_W'(V_RES - 1));

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      FB_ADDR     <= '0;
      FB_COLOR    <= '0;
      FB_WE       <= 1'b0;
      FRAME_DONE  <= 1'b0;
      ERR_OVERRUN <= 1'b0;
      ERR_SHORT   <= 1'b0;
    end else begin
      FB_WE      <= 1'b0;
      FRAME_DONE <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_fall) begin
            row_q       <= '0;
            col_q       <= '0;
            ERR_OVERRUN <= 1'b0;
            ERR_SHORT   <= 1'b0;
            state_q     <= RECV;
          end
        end
        RECV: begin
          if (wr_rise) begin
            FB_WE    <= 1'b1;
            FB_ADDR  <= {row_q, col_q};
            FB_COLOR <= data_sync;
            if (last_px) begin
              FRAME_DONE <= 1'b1;
            end else if (col_end) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
          // A closing window in the same cycle as the final pixel is a complete frame.
          if (frame_rise) begin
            state_q <= IDLE;
            if (!(wr_rise && last_px)) begin
              ERR_SHORT <= 1'b1;
            end
          end else if (wr_rise && last_px) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (wr_rise) begin
            ERR_OVERRUN <= 1'b1;
          end
          if (frame_rise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = (state_q == RECV);

endmodule

// File: tb/tb_mcu_pixel_rx.sv
// Directed bench for mcu_pixel_rx: table of spot-checked writes in a full
// frame plus hand sequences for overrun, short frame and async reset.
module tb_mcu_pixel_rx;

  logic        CLK_100MHz = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  MCU_DATA = 8'h00;
  logic        MCU_WR = 1'b0;
  logic        MCU_FRAME_N = 1'b1;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_COLOR;
  logic        FB_WE;
  logic        FRAME_DONE;
  logic        ERR_OVERRUN;
  logic        ERR_SHORT;
  logic        BUSY;

  mcu_pixel_rx dut (
    .CLK_100MHz  (CLK_100MHz),
    .RST_N       (RST_N),
    .MCU_DATA    (MCU_DATA),
    .MCU_WR      (MCU_WR),
    .MCU_FRAME_N (MCU_FRAME_N),
    .FB_ADDR     (FB_ADDR),
    .FB_COLOR    (FB_COLOR),
    .FB_WE       (FB_WE),
    .FRAME_DONE  (FRAME_DONE),
    .ERR_OVERRUN (ERR_OVERRUN),
    .ERR_SHORT   (ERR_SHORT),
    .BUSY        (BUSY)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  localparam int LogN = 12000;

  logic [12:0] log_addr [LogN];
  logic [7:0]  log_color [LogN];
  logic        log_done [LogN];
  int          n_wr = 0;
  int          n_done = 0;
  int          n_done_alone = 0;
  int          n_out_of_range = 0;

  // Write-port monitor, sampled away from the active edge.
  always @(negedge CLK_100MHz) begin
    if (FB_WE) begin
      if (n_wr < LogN) begin
        log_addr[n_wr]  = FB_ADDR;
        log_color[n_wr] = FB_COLOR;
        log_done[n_wr]  = FRAME_DONE;
      end
      n_wr = n_wr + 1;
      if (FB_ADDR[6:0] >= 7'd80 || FB_ADDR[12:7] >= 6'd60) n_out_of_range = n_out_of_range + 1;
    end
    if (FRAME_DONE) begin
      n_done = n_done + 1;
      if (!FB_WE) n_done_alone = n_done_alone + 1;
    end
  end

  int total = 0;
  int bad = 0;
  logic [4:0] we_pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 1 clock data setup, WR high 3 clocks, low 3 clocks; FB_WE sampled at 5 negedges.
  task automatic strobe(input logic [7:0] d);
    MCU_DATA = d;
    @(negedge CLK_100MHz);
    MCU_WR = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK_100MHz);
      we_pat[5-k] = FB_WE;
      if (k == 3) MCU_WR = 1'b0;
    end
  endtask

  task automatic frame_n(input logic v);
    MCU_FRAME_N = v;
    repeat (8) @(negedge CLK_100MHz);
  endtask

  function automatic logic [7:0] pix(input int i);
    if (i == 0) return 8'hE0;
    if (i == 1) return 8'h1C;
    if (i == 2) return 8'h03;
    return 8'(i);
  endfunction

  typedef struct {
    int          idx;
    logic [12:0] addr;
    logic [7:0]  color;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int base;
    int seq_bad;
    logic [12:0] exp_a;

    tbl[0] = '{0,    13'h0000, 8'hE0};
    tbl[1] = '{1,    13'h0001, 8'h1C};
    tbl[2] = '{2,    13'h0002, 8'h03};
    tbl[3] = '{79,   13'h004F, 8'h4F};
    tbl[4] = '{80,   13'h0080, 8'h50};
    tbl[5] = '{159,  13'h00CF, 8'h9F};
    tbl[6] = '{160,  13'h0100, 8'hA0};
    tbl[7] = '{4799, 13'h1DCF, 8'hBF};

    repeat (3) @(negedge CLK_100MHz);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK_100MHz);
    chk("rst_addr", 32'(FB_ADDR), 32'h0);
    chk("rst_color", 32'(FB_COLOR), 32'h0);
    chk("rst_flags", 32'({FB_WE, FRAME_DONE, ERR_OVERRUN, ERR_SHORT, BUSY}), 32'h0);

    base = n_wr;
    strobe(8'h77);
    chk("idle_strobe_writes", 32'(n_wr - base), 32'd0);

    // Frame 1: complete frame.
    frame_n(1'b0);
    chk("f1_busy_open", 32'(BUSY), 32'd1);
    base = n_wr;
    for (int i = 0; i < 4800; i++) begin
      strobe(pix(i));
      if (i == 0) chk("latency_pattern", 32'(we_pat), 32'b00010);
      if (i == 2) chk("f1_busy_3px", 32'(BUSY), 32'd1);
    end
    chk("f1_writes", 32'(n_wr - base), 32'd4800);
    seq_bad = 0;
    for (int i = 0; i < 4800; i++) begin
      exp_a = {6'(i / 80), 7'(i % 80)};
      if (log_addr[base+i] !== exp_a || log_color[base+i] !== pix(i)) seq_bad++;
    end
    chk("f1_addr_color_seq", 32'(seq_bad), 32'd0);
    foreach (tbl[t]) begin
      chk($sformatf("tbl_addr_%0d", tbl[t].idx), 32'(log_addr[base+tbl[t].idx]),
          32'(tbl[t].addr));
      chk($sformatf("tbl_color_%0d", tbl[t].idx), 32'(log_color[base+tbl[t].idx]),
          32'(tbl[t].color));
    end
    chk("f1_done_on_last", 32'(log_done[base+4799]), 32'd1);
    chk("f1_done_count", 32'(n_done), 32'd1);
    chk("done_without_we", 32'(n_done_alone), 32'd0);
    chk("f1_busy_full", 32'(BUSY), 32'd0);
    chk("f1_errs", 32'({ERR_OVERRUN, ERR_SHORT}), 32'd0);
    chk("addr_out_of_range", 32'(n_out_of_range), 32'd0);
    frame_n(1'b1);
    chk("f1_close_errs", 32'({ERR_OVERRUN, ERR_SHORT, BUSY}), 32'd0);

    // Frame 2: full frame then an extra strobe.
    frame_n(1'b0);
    base = n_wr;
    for (int i = 0; i < 4800; i++) strobe(pix(i));
    chk("f2_writes", 32'(n_wr - base), 32'd4800);
    base = n_wr;
    strobe(8'h55);
    chk("overrun_no_write", 32'(n_wr - base), 32'd0);
    chk("overrun_flag", 32'(ERR_OVERRUN), 32'd1);
    frame_n(1'b1);
    chk("overrun_sticky", 32'(ERR_OVERRUN), 32'd1);
    frame_n(1'b0);
    chk("overrun_cleared", 32'(ERR_OVERRUN), 32'd0);
    chk("f3_busy", 32'(BUSY), 32'd1);

    // Frame 3: closed after 100 pixels.
    base = n_wr;
    for (int i = 0; i < 100; i++) strobe(pix(i));
    chk("f3_writes", 32'(n_wr - base), 32'd100);
    chk("f3_first_addr", 32'(log_addr[base]), 32'h0000);
    chk("f3_last_addr", 32'(log_addr[base+99]), 32'h0093);
    frame_n(1'b1);
    chk("short_flag", 32'(ERR_SHORT), 32'd1);
    chk("short_idle", 32'(BUSY), 32'd0);
    base = n_wr;
    strobe(8'h11);
    strobe(8'h22);
    chk("short_no_write", 32'(n_wr - base), 32'd0);

    // Frame 4: asynchronous reset mid-frame.
    frame_n(1'b0);
    for (int i = 0; i < 5; i++) strobe(8'hC0 + 8'(i));
    chk("pre_rst_addr", 32'(FB_ADDR), 32'h0004);
    @(posedge CLK_100MHz);
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_addr", 32'(FB_ADDR), 32'h0);
    chk("async_rst_color", 32'(FB_COLOR), 32'h0);
    chk("async_rst_flags", 32'({FB_WE, FRAME_DONE, ERR_OVERRUN, ERR_SHORT, BUSY}), 32'h0);
    @(negedge CLK_100MHz);
    RST_N = 1'b1;
    base = n_wr;
    for (int i = 0; i < 3; i++) strobe(8'h99);
    chk("post_rst_no_write", 32'(n_wr - base), 32'd0);
    chk("post_rst_idle", 32'(BUSY), 32'd0);
    frame_n(1'b1);
    frame_n(1'b0);
    base = n_wr;
    strobe(8'hA5);
    chk("restart_writes", 32'(n_wr - base), 32'd1);
    chk("restart_addr", 32'(log_addr[base]), 32'h0000);
    chk("restart_color", 32'(log_color[base]), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
